alu_operand_stage: RTL
======================

Name: alu_operand_stage

Overview:
- Issue/writeback stage wrapped around the 16-bit ALU: accepts a 16-bit instruction, reads operands from an 8x16 register file and drives registered ina/inb/cmd into the ALU.
- Captures the combinational ALU result one cycle later and writes it back to the destination register.
- Forwards the in-flight result to a dependent instruction, so back-to-back issue never stalls.

Parameters:
- NREG, 8, register count (power of two; register address width = log2(NREG) = 3)
- IMMW, 5, immediate field width, zero-extended to 16

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- instr  input  16  [15:12] cmd, [11:9] rd, [8:6] rs, [5] immediate flag, [4:0] rt (bits 2:0) or imm5
- instr_valid  input  1  instr present this cycle
- instr_ready  output  1  stage accepts instr this cycle
- stall  input  1  downstream hold; freezes the stage
- ina  output  16  registered ALU operand A
- inb  output  16  registered ALU operand B
- cmd  output  4  registered ALU opcode
- alu_valid  output  1  ina/inb/cmd hold a live instruction
- alu_out  input  16  combinational ALU result for the current ina/inb/cmd
- dbg_addr  input  3  debug read address
- dbg_data  output  16  rf[dbg_addr], combinational, architectural (post-writeback) value

Behaviour:
- Reset (synchronous, rst sampled high at posedge):
  - all registers, ina, inb, cmd, alu_valid and rd_q cleared to 0
  - instr_ready = 0 while rst is high
  - reset mid-operation discards the in-flight instruction; no writeback happens in that cycle
- Handshake: instr_ready = ~rst & ~stall. An instruction is accepted when instr_valid & instr_ready at posedge. instr is not required to be held once accepted.
- Register file:
  - r0 always reads 0; writes to r0 are dropped
  - a writeback and a read of the same register in the same cycle returns the new value (write-first)
- Operand select:
  - A = R(rs)
  - B = zero-extended imm5 if bit5 = 1, else R(rt), where rt = instr[2:0] and instr[4:3] are ignored
- Forwarding: if alu_valid & ~stall and rd_q != 0 and the source equals rd_q, use alu_out in place of the register value. This applies independently to A and B.
- Pipeline, with 1-cycle issue-to-ALU latency:
  - on accept: ina/inb/cmd <= selected operands and instr[15:12]; rd_q <= rd; alu_valid <= 1
  - no accept and ~stall: alu_valid <= 0; ina/inb/cmd hold their values
  - writeback: at any posedge with alu_valid & ~stall & ~rst, rf[rd_q] <= alu_out
  - a result is architecturally visible on dbg_data the cycle after writeback
- Stall: while stall = 1, ina/inb/cmd/alu_valid/rd_q and the register file are frozen; no accept and no writeback occur. On release, writeback occurs at the first posedge with stall = 0.
- State: two-state control, EMPTY (alu_valid = 0) and BUSY (alu_valid = 1).
  - EMPTY -> BUSY on accept
  - BUSY -> BUSY on accept, with simultaneous writeback of the old instruction
  - BUSY -> EMPTY on writeback without accept
  - stall holds the current state
- All arithmetic, shift and flag semantics belong to the ALU. This stage only passes cmd through unmodified, including 4'b1111.

Test Plan:
- Reset then immediates:
  - issue cmd=0001 rd=1 rs=0 imm=5, then cmd=0001 rd=2 rs=0 imm=7
  - after drain, dbg r1=5 and r2=7; ina=0, inb=7 on the second ALU cycle
- Back-to-back RAW: r1=5, r2=7, then add r3=r1+r2, immediately followed by add r4=r3+r3
  - second issue drives ina=inb=12 via forwarding
  - final r4=24 with no bubble (instr_ready never drops)
- r0 protection: issue cmd=0001 rd=0 rs=0 imm=9, then read r0 as a source
  - ina=0, and dbg r0=0
- Stall: assert stall for 3 cycles while alu_valid=1 (rd=5), holding instr_valid high
  - instr_ready=0 and ina/inb/cmd stable throughout
  - r5 unchanged until the first unstalled posedge, then written exactly once
  - the held instr is accepted on that same posedge
- Reset mid-flight: assert rst in the cycle an instruction with rd=6 is in the ALU
  - r6 stays 0; alu_valid=0, instr_ready=0 during rst
  - the instruction after deassert executes normally
- Register B path: imm flag 0 with instr[4:0]=5'b11010
  - B comes from r2 (upper bits ignored)
  - with r2=3 and cmd=1001, inb=3

Source files
------------

// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage_if
// Description : Issue handshake and ALU operand/result bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_operand_stage_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic [15:0] ina;
  logic [15:0] inb;
  logic [3:0]  cmd;
  logic        alu_valid;
  logic [15:0] alu_out;

  // The environment side: instruction source, stall source and the ALU itself.
  modport master (
    output instr, instr_valid, stall, alu_out,
    input  instr_ready, ina, inb, cmd, alu_valid
  );

  modport slave (
    input  instr, instr_valid, stall, alu_out,
    output instr_ready, ina, inb, cmd, alu_valid
  );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : Issue/writeback stage around a 16-bit ALU with result forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
  parameter int NREG = 8,
  parameter int IMMW = 5
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  alu_operand_stage_if.slave             bus,
  input  wire logic [$clog2(NREG)-1:0]   dbg_addr,
  output logic      [15:0]               dbg_data
);

  localparam int AW = $clog2(NREG);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_BUSY  = 1'b1;

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic          w_busy;
  logic          w_accept;
  logic          w_wb;
  logic          w_fwd_en;

  logic [AW-1:0] w_rs;
  logic [AW-1:0] w_rt;
  logic [AW-1:0] w_rd;
  logic [AW-1:0] r_rd_q;

  logic [15:0]   w_imm;
  logic [15:0]   w_op_a;
  logic [15:0]   w_op_b;
  logic [15:0]   r_ina;
  logic [15:0]   r_inb;
  logic [3:0]    r_cmd;

  logic [15:0]   w_rf [NREG];

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!bus.stall) begin
      w_state_nxt = w_accept ? S_BUSY : S_EMPTY;
    end
  end

  always_comb begin
    bus.instr_ready = ~rst & ~bus.stall;
    w_busy          = (r_state == S_BUSY);
    bus.alu_valid   = w_busy;
  end

  assign w_accept = bus.instr_valid & bus.instr_ready;
  assign w_wb     = w_busy & ~bus.stall & ~rst;
  // Forwarding is only meaningful when the in-flight result retires this cycle.
  assign w_fwd_en = w_busy & ~bus.stall & (r_rd_q != '0);

  // --------------------------------------------------------------------------
  // Instruction decode
  // --------------------------------------------------------------------------
  assign w_rd  = bus.instr[9 +: AW];
  assign w_rs  = bus.instr[6 +: AW];
  assign w_rt  = bus.instr[0 +: AW];
  assign w_imm = {{(16-IMMW){1'b0}}, bus.instr[IMMW-1:0]};

  // --------------------------------------------------------------------------
  // Register file; r0 is a hard zero and never stores anything.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
      if (gi == 0) begin : g_zero
        assign w_rf[gi] = 16'h0000;
      end else begin : g_reg
        logic [15:0] r_q;
        always_ff @(posedge clk) begin
          if (rst) begin
            r_q <= 16'h0000;
          end else if (w_wb && (r_rd_q == AW'(gi))) begin
            r_q <= bus.alu_out;
          end
        end
        assign w_rf[gi] = r_q;
      end
    end
  endgenerate

  assign dbg_data = w_rf[dbg_addr];

  // --------------------------------------------------------------------------
  // Operand select with forwarding (also gives write-first read behaviour)
  // --------------------------------------------------------------------------
  always_comb begin
    w_op_a = w_rf[w_rs];
    if (w_fwd_en && (w_rs == r_rd_q)) begin
      w_op_a = bus.alu_out;
    end
  end

  always_comb begin
    w_op_b = w_rf[w_rt];
    if (w_fwd_en && (w_rt == r_rd_q)) begin
      w_op_b = bus.alu_out;
    end
    if (bus.instr[5]) begin
      w_op_b = w_imm;
    end
  end

  // --------------------------------------------------------------------------
  // ALU input registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ina  <= 16'h0000;
      r_inb  <= 16'h0000;
      r_cmd  <= 4'h0;
      r_rd_q <= '0;
    end else if (w_accept) begin
      r_ina  <= w_op_a;
      r_inb  <= w_op_b;
      r_cmd  <= bus.instr[15:12];
      r_rd_q <= w_rd;
    end
  end

  assign bus.ina = r_ina;
  assign bus.inb = r_inb;
  assign bus.cmd = r_cmd;

endmodule
`default_nettype wire
